// File: rtl/mdu_div_seq_pkg.sv
// Shared encodings for the MDU divide sequencer: sign modes and FSM states.
package mdu_div_seq_pkg;

    localparam logic DIV_UNSIGNED = 1'b0;
    localparam logic DIV_SIGNED   = 1'b1;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_CALC = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/mdu_div_seq_sign.sv
// Conditional two's-complement negate, used for operand magnitude and result sign fix-up.
module div_sign_cond #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = neg ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;
    end

endmodule

// File: rtl/mdu_div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU; one quotient bit per cycle.
module mdu_div_seq
    import mdu_div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    div_state_e state, state_n;
    logic       accept;

    logic [WIDTH-1:0] a_r, b_r;
    logic             sop_r;
    logic             qneg, rneg;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
    logic [WIDTH+1:0] sh, diff;
    logic             ge;
    logic             b_zero;

    assign b_zero = (b_r == '0);

    div_sign_cond #(.WIDTH(WIDTH)) u_abs_a (
        .neg  (sop_r == DIV_SIGNED && a_r[WIDTH-1]),
        .din  (a_r),
        .dout (a_abs)
    );

    div_sign_cond #(.WIDTH(WIDTH)) u_abs_b (
        .neg  (sop_r == DIV_SIGNED && b_r[WIDTH-1]),
        .din  (b_r),
        .dout (b_abs)
    );

    div_sign_cond #(.WIDTH(WIDTH)) u_fix_q (
        .neg  (qneg),
        .din  (quo),
        .dout (q_fix)
    );

    div_sign_cond #(.WIDTH(WIDTH)) u_fix_r (
        .neg  (rneg),
        .din  (rem[WIDTH-1:0]),
        .dout (r_fix)
    );

    // Trial subtract is two bits wider than the operand so its MSB is a clean borrow.
    always_comb begin
        sh   = {rem, quo[WIDTH-1]};
        diff = sh - {2'b00, b_mag};
        ge   = ~diff[WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start) begin
                    state_n = DIV_PREP;
                    accept  = 1'b1;
                end
            end
            DIV_PREP: begin
                busy    = 1'b1;
                state_n = b_zero ? DIV_DONE : DIV_CALC;
            end
            DIV_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_ONE) state_n = DIV_FIX;
            end
            DIV_FIX: begin
                busy    = 1'b1;
                state_n = DIV_DONE;
            end
            DIV_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_n = DIV_PREP;
                    accept  = 1'b1;
                end else begin
                    state_n = DIV_IDLE;
                end
            end
            default: state_n = DIV_IDLE;
        endcase
        // Flush beats every transition and drops a coincident request.
        if (flush) begin
            state_n = DIV_IDLE;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            sop_r       <= DIV_UNSIGNED;
            qneg        <= 1'b0;
            rneg        <= 1'b0;
            b_mag       <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                a_r   <= dividend;
                b_r   <= divisor;
                sop_r <= signed_op;
            end
            if (state == DIV_PREP && !flush) begin
                qneg  <= (sop_r == DIV_SIGNED) & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                rneg  <= (sop_r == DIV_SIGNED) & a_r[WIDTH-1];
                b_mag <= b_abs;
                quo   <= a_abs;
                rem   <= '0;
                cnt   <= CNT_INIT;
                if (b_zero) begin
                    quotient    <= '1;
                    remainder   <= a_r;
                    div_by_zero <= 1'b1;
                end
            end
            if (state == DIV_CALC) begin
                rem <= ge ? diff[WIDTH:0] : sh[WIDTH:0];
                quo <= {quo[WIDTH-2:0], ge};
                cnt <= cnt - CNT_ONE;
            end
            // A flushed op leaves the previous result visible.
            if (state == DIV_FIX && !flush) begin
                quotient    <= q_fix;
                remainder   <= r_fix;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mdu_div_seq.sv
// Directed + random bench for mdu_div_seq against an arithmetic reference model.
module tb_mdu_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, signed_op, flush;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] last_q, last_r;

    mdu_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .flush       (flush),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        z = 1'b0;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int poke);
        logic [W-1:0] eq, er;
        logic         ez;
        int n, nb, lat;
        bit seen;
        model(a, b, s, eq, er, ez);
        lat = (b == 0) ? 2 : W + 3;
        dividend = a; divisor = b; signed_op = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = ~s;
        n = 0; nb = 0; seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) seen = 1;
            start = (n == poke && !seen);
        end
        start = 1'b0;
        if (!seen) begin
            vectors++; miscompares++;
            $error("FAIL timeout observed=no_done expected=done_by_cycle_%0d", lat);
            return;
        end
        chk("latency", W'(n), W'(lat));
        chk("busy_cycles", W'(nb), W'(lat - 1));
        chk("busy_at_done", W'(busy), W'(0));
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", W'(div_by_zero), W'(ez));
        last_q = eq; last_r = er;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        bit           saw_done;

        rst = 1'b1; start = 1'b0; flush = 1'b0; signed_op = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_q", quotient, '0);
        chk("rst_r", remainder, '0);
        chk("rst_dbz", W'(div_by_zero), W'(0));

        do_div(32'd100, 32'd7, 1'b0, 0);
        chk("divu_100_7_q", quotient, 32'd14);
        @(negedge clk);
        do_div(-32'sd7, 32'd2, 1'b1, 0);
        chk("div_m7_2_q", quotient, 32'hFFFF_FFFD);
        chk("div_m7_2_r", remainder, 32'hFFFF_FFFF);
        do_div(32'd7, -32'sd2, 1'b1, 0);
        chk("div_7_m2_r", remainder, 32'd1);
        @(negedge clk);
        do_div(32'h1234_5678, 32'd0, 1'b1, 0);
        @(negedge clk);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        chk("ovf_q", quotient, 32'h8000_0000);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        chk("ovfu_r", remainder, 32'h8000_0000);

        // Flush mid-op with a coincident start: both dropped, results held.
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd3;
        @(posedge clk);
        #1 flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("flush_busy", W'(busy), W'(0));
        chk("flush_q_hold", quotient, last_q);
        chk("flush_r_hold", remainder, last_r);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        chk("flush_no_done", W'(saw_done), W'(0));
        do_div(32'd9, 32'd2, 1'b0, 0);

        // Start while busy is ignored.
        @(negedge clk);
        do_div(32'd1000, 32'd33, 1'b0, 5);
        chk("ignored_start_q", quotient, 32'd30);

        // Mid-op reset.
        @(negedge clk);
        dividend = 32'd555; divisor = 32'd5; signed_op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        chk("midrst_q", quotient, '0);
        chk("midrst_r", remainder, '0);
        chk("midrst_dbz", W'(div_by_zero), W'(0));

        // Back-to-back and random operations.
        do_div(32'd77, 32'd0, 1'b0, 0);
        do_div(32'd77, 32'd8, 1'b0, 0);
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = $urandom;
                default: rb = -W'($urandom_range(1, 15));
            endcase
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            do_div(ra, rb, rs, (i % 4 == 0) ? 3 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
